vga_pixel_fifo: RTL and testbench
=================================

# vga_pixel_fifo

Single-clock pixel buffer that sits directly upstream of the VGA timing controller and feeds its 10-bit iRed/iGreen/iBlue inputs. A pixel producer (frame-buffer reader or test-pattern source) pushes 30-bit RGB words with a write strobe. The VGA controller pops one word per cycle through its request output. The block reports fill level, asks the producer for more data when running low, and flags underflow and overflow so display glitches can be traced.

## Interface
- DEPTH, 512: FIFO depth in pixels; power of two, at least 4.
- ADDR_W, 9: log2(DEPTH).
- FETCH_LEVEL, 256: oFetch asserts while the level is below this value; range 1..DEPTH.

Ports:
- iCLK  in  1  pixel clock (VGA clock domain); all logic on the rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iClear  in  1  synchronous flush, e.g. at frame start.
- iWrite  in  1  write strobe from the producer.
- iWR_Red, iWR_Green, iWR_Blue  in  10 each  write pixel data.
- oFull  out  1  level == DEPTH.
- oFetch  out  1  level < FETCH_LEVEL.
- iRequest  in  1  pop request; driven from the VGA controller's oRequest.
- oRed, oGreen, oBlue  out  10 each  registered read data, connected to the controller's iRed/iGreen/iBlue.
- oEmpty  out  1  level == 0.
- oLevel  out  ADDR_W+1  current occupancy, 0..DEPTH.
- oUnderflow  out  1  sticky; set by a request while empty.
- oOverflow  out  1  sticky; set by a write while full.

## Operation
- Storage is a DEPTH x 30 RAM with synchronous read. RAM contents are never reset.
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits wide. The extra MSB distinguishes full from empty. oLevel = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
- All decisions in a cycle use the state as it was before the clock edge.
- Write:
  - iWrite=1 and not full: store the pixel at wr_ptr[ADDR_W-1:0], then increment wr_ptr.
  - iWrite=1 and full: drop the pixel and set oOverflow.
- Read:
  - iRequest=1 and not empty: on the next edge, oRGB <= mem[rd_ptr], then increment rd_ptr.
  - iRequest=1 and empty: on the next edge, oRGB <= 0 and set oUnderflow. rd_ptr is unchanged.
  - iRequest=0: on the next edge, oRGB <= 0. Outputs are black whenever no pixel was popped.
- Simultaneous read and write:
  - Both proceed, and the level is unchanged.
  - When full: the read pops, but the write is still rejected because the pre-edge state was full, and oOverflow is set.
  - When empty: the write stores, and the read underflows. There is no write-to-read bypass.
- Pointer wrap-around: pointers wrap naturally at 2^(ADDR_W+1). The RAM address uses the low ADDR_W bits.
- iClear:
  - Takes priority over read and write in the same cycle.
  - Effect: wr_ptr = rd_ptr = 0; oRGB <= 0; oUnderflow and oOverflow cleared.
  - Writes and requests in that cycle are ignored. No flags are set by them.
- Status outputs:
  - oFull, oEmpty, oFetch and oLevel are combinational from the pointers.
  - Sticky flags clear only on reset or iClear.

## Timing
- Reset state (iRST_N=0, asynchronous):
  - Pointers = 0, oRGB = 0, oUnderflow = 0, oOverflow = 0.
  - Hence oEmpty=1, oFull=0, oLevel=0, oFetch=1.
- Reset deasserted mid-frame: the block restarts empty. The first requests underflow until the producer refills.
- Read latency is exactly 1 cycle: request sampled at edge N, data valid after edge N and held until edge N+1. This matches the VGA controller, which asserts oRequest one pixel ahead of the active window.
- Write-to-readable latency is 1 cycle: data written at edge N can be popped by a request sampled at edge N+1.
- Status updates: oLevel, oFull, oEmpty and oFetch update in the same cycle as the pointer change, i.e. after the edge.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then write 4 pixels (R=1..4, G=R+100, B=R+200), then assert iRequest for 4 cycles -> oRed = 1, 2, 3, 4 on the cycles following each request; oLevel goes 4→0; oEmpty=1 at the end; no flags set.
- Fill with DEPTH writes, then one more write -> oFull=1, oLevel=512, oOverflow=1. After draining, the 512 values read out in order, and the extra pixel is absent.
- Request while empty -> oRGB = 0 on the next cycle, oUnderflow=1, oLevel stays 0. A following write then request returns the written value, and oUnderflow stays 1.
- FIFO at level 300, continuous reads only -> oFetch goes 0→1 on the cycle the level reaches 255. With concurrent read and write at level 256, the level holds at 256 and oFetch stays 0.
- Pointer wrap: stream 3×DEPTH pixels with interleaved read/write while keeping the level between 1 and 10 -> every value reads back in order, with no flags set.
- iClear asserted together with iWrite and iRequest at level 7 with both flags set -> next cycle oLevel=0, oEmpty=1, oRGB=0, both flags 0. Async reset mid-stream -> all outputs at their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/vga_pixel_fifo.sv
// Single-clock pixel FIFO feeding the VGA timing controller: 30-bit RGB words in,
// one registered pixel out per request, with level/fetch status and sticky error flags.
module vga_pixel_fifo #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned FETCH_LEVEL = 256
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iClear,
  input  logic              iWrite,
  input  logic [9:0]        iWR_Red,
  input  logic [9:0]        iWR_Green,
  input  logic [9:0]        iWR_Blue,
  output logic              oFull,
  output logic              oFetch,
  input  logic              iRequest,
  output logic [9:0]        oRed,
  output logic [9:0]        oGreen,
  output logic [9:0]        oBlue,
  output logic              oEmpty,
  output logic [ADDR_W:0]   oLevel,
  output logic              oUnderflow,
  output logic              oOverflow
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned COLOR_W = 10;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } pixel_t;

  pixel_t           mem [DEPTH];
  pixel_t           wrPixel;
  pixel_t           rdPixel;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] level;
  logic             isFull;
  logic             isEmpty;
  logic             doWrite;
  logic             doRead;

  // Status is derived from the pre-edge pointers; the extra pointer MSB separates full from empty.
  assign wrPixel = '{red: iWR_Red, green: iWR_Green, blue: iWR_Blue};
  assign level   = wrPtr - rdPtr;
  assign isFull  = (level == PTR_W'(DEPTH));
  assign isEmpty = (level == PTR_W'(0));
  assign doWrite = iWrite   & ~isFull  & ~iClear;
  assign doRead  = iRequest & ~isEmpty & ~iClear;

  assign oLevel = level;
  assign oFull  = isFull;
  assign oEmpty = isEmpty;
  assign oFetch = (level < PTR_W'(FETCH_LEVEL));
  assign oRed   = rdPixel.red;
  assign oGreen = rdPixel.green;
  assign oBlue  = rdPixel.blue;

  // Pixel storage; contents are intentionally not reset.
  always_ff @(posedge iCLK) begin
    if (doWrite) begin
      mem[wrPtr[ADDR_W-1:0]] <= wrPixel;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (iClear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (doRead)  rdPtr <= rdPtr + PTR_W'(1);
    end
  end

  // Output goes black on any cycle without a successful pop.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdPixel <= '0;
    end else if (doRead) begin
      rdPixel <= mem[rdPtr[ADDR_W-1:0]];
    end else begin
      rdPixel <= '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oUnderflow <= 1'b0;
      oOverflow  <= 1'b0;
    end else if (iClear) begin
      oUnderflow <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      if (iRequest && isEmpty) oUnderflow <= 1'b1;
      if (iWrite && isFull)    oOverflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Randomized and directed bench for vga_pixel_fifo against a queue-based reference model.
module tb_vga_pixel_fifo;

  localparam int unsigned DEPTH       = 512;
  localparam int unsigned ADDR_W      = 9;
  localparam int unsigned FETCH_LEVEL = 256;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iClear = 1'b0;
  logic        iWrite = 1'b0;
  logic        iRequest = 1'b0;
  logic [9:0]  iWR_Red = '0;
  logic [9:0]  iWR_Green = '0;
  logic [9:0]  iWR_Blue = '0;
  logic        oFull, oFetch, oEmpty, oUnderflow, oOverflow;
  logic [9:0]  oRed, oGreen, oBlue;
  logic [ADDR_W:0] oLevel;

  vga_pixel_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FETCH_LEVEL(FETCH_LEVEL)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iClear(iClear), .iWrite(iWrite),
    .iWR_Red(iWR_Red), .iWR_Green(iWR_Green), .iWR_Blue(iWR_Blue),
    .oFull(oFull), .oFetch(oFetch), .iRequest(iRequest),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oEmpty(oEmpty),
    .oLevel(oLevel), .oUnderflow(oUnderflow), .oOverflow(oOverflow)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: an ordered queue of pixels plus the visible output and flags.
  logic [29:0] modelQ[$];
  logic [29:0] modelRgb = '0;
  bit          modelUnder = 1'b0;
  bit          modelOver = 1'b0;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".level"}, 32'(oLevel), 32'(modelQ.size()));
    checkVal({tag, ".full"},  32'(oFull),  32'(modelQ.size() == DEPTH));
    checkVal({tag, ".empty"}, 32'(oEmpty), 32'(modelQ.size() == 0));
    checkVal({tag, ".fetch"}, 32'(oFetch), 32'(modelQ.size() < FETCH_LEVEL));
    checkVal({tag, ".rgb"},   32'({oRed, oGreen, oBlue}), 32'(modelRgb));
    checkVal({tag, ".under"}, 32'(oUnderflow), 32'(modelUnder));
    checkVal({tag, ".over"},  32'(oOverflow),  32'(modelOver));
  endtask

  function automatic void modelReset();
    modelQ.delete();
    modelRgb   = '0;
    modelUnder = 1'b0;
    modelOver  = 1'b0;
  endfunction

  // Applies one edge worth of behaviour using the pre-edge occupancy.
  function automatic void modelEdge(input bit clr, input bit wr, input bit rq, input logic [29:0] d);
    int pre;
    pre = modelQ.size();
    if (clr) begin
      modelReset();
      return;
    end
    modelRgb = '0;
    if (rq) begin
      if (pre > 0) modelRgb = modelQ.pop_front();
      else         modelUnder = 1'b1;
    end
    if (wr) begin
      if (pre < DEPTH) modelQ.push_back(d);
      else             modelOver = 1'b1;
    end
  endfunction

  task automatic step(input string tag, input bit clr, input bit wr, input bit rq, input logic [29:0] d);
    iClear   = clr;
    iWrite   = wr;
    iRequest = rq;
    {iWR_Red, iWR_Green, iWR_Blue} = d;
    @(posedge iCLK);
    modelEdge(clr, wr, rq, d);
    #1;
    checkAll(tag);
  endtask

  function automatic logic [29:0] rgbOf(input int r);
    return {10'(r), 10'(r + 100), 10'(r + 200)};
  endfunction

  initial begin
    // Reset state
    #1;
    checkAll("reset");
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;
    checkAll("post_reset");

    // Four pixels in, four out
    for (int r = 1; r <= 4; r++) step("basic_wr", 0, 1, 0, rgbOf(r));
    for (int k = 1; k <= 4; k++) begin
      step("basic_rd", 0, 0, 1, '0);
      checkVal("basic_red", 32'(oRed), 32'(k));
      checkVal("basic_lvl", 32'(oLevel), 32'(4 - k));
    end
    step("basic_idle", 0, 0, 0, '0);
    checkVal("basic_empty", 32'(oEmpty), 32'd1);

    // Fill to full, one extra write, then drain in order
    for (int i = 0; i < DEPTH; i++) step("fill_wr", 0, 1, 0, 30'(i * 7 + 3));
    step("fill_extra", 0, 1, 0, 30'h3FFF_FFFF);
    checkVal("fill_full", 32'(oFull), 32'd1);
    checkVal("fill_level", 32'(oLevel), 32'(DEPTH));
    checkVal("fill_over", 32'(oOverflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain_rd", 0, 0, 1, '0);
      checkVal("drain_val", 32'({oRed, oGreen, oBlue}), 32'(i * 7 + 3));
    end
    step("drain_extra", 0, 0, 1, '0);
    checkVal("drain_black", 32'({oRed, oGreen, oBlue}), 32'd0);

    // Underflow while empty, then recovery with a normal pixel
    step("clr", 1, 0, 0, '0);
    step("uf_req", 0, 0, 1, '0);
    checkVal("uf_flag", 32'(oUnderflow), 32'd1);
    checkVal("uf_level", 32'(oLevel), 32'd0);
    step("uf_wr", 0, 1, 0, rgbOf(55));
    step("uf_rd", 0, 0, 1, '0);
    checkVal("uf_data", 32'({oRed, oGreen, oBlue}), 32'(rgbOf(55)));
    checkVal("uf_sticky", 32'(oUnderflow), 32'd1);

    // Fetch threshold crossing and concurrent read/write at the threshold
    step("clr", 1, 0, 0, '0);
    for (int i = 0; i < 300; i++) step("fetch_wr", 0, 1, 0, 30'($urandom));
    for (int i = 0; i < 44; i++) step("fetch_rd", 0, 0, 1, '0);
    checkVal("fetch_256", 32'(oFetch), 32'd0);
    step("fetch_rd", 0, 0, 1, '0);
    checkVal("fetch_255", 32'(oFetch), 32'd1);
    step("fetch_wr", 0, 1, 0, 30'($urandom));
    for (int i = 0; i < 8; i++) begin
      step("fetch_rw", 0, 1, 1, 30'($urandom));
      checkVal("fetch_rw_lvl", 32'(oLevel), 32'd256);
      checkVal("fetch_rw_f", 32'(oFetch), 32'd0);
    end

    // Pointer wrap: 3*DEPTH pixels with level kept in 1..10
    begin
      int written;
      bit wr, rq;
      step("clr", 1, 0, 0, '0);
      for (int i = 0; i < 5; i++) step("wrap_pre", 0, 1, 0, 30'($urandom));
      written = 5;
      while (written < 3 * DEPTH) begin
        wr = (modelQ.size() < 10) && ($urandom_range(0, 3) != 0);
        rq = (modelQ.size() > 1) && ($urandom_range(0, 3) != 0);
        step("wrap", 0, wr, rq, 30'($urandom));
        if (wr) written++;
      end
      checkVal("wrap_under", 32'(oUnderflow), 32'd0);
      checkVal("wrap_over", 32'(oOverflow), 32'd0);
    end

    // Clear with both flags set at level 7, write and request also asserted
    step("clr", 1, 0, 0, '0);
    step("cf_uf", 0, 0, 1, '0);
    for (int i = 0; i <= DEPTH; i++) step("cf_fill", 0, 1, 0, 30'($urandom));
    for (int i = 0; i < DEPTH - 7; i++) step("cf_drain", 0, 0, 1, '0);
    checkVal("cf_lvl7", 32'(oLevel), 32'd7);
    step("cf_clear", 1, 1, 1, 30'($urandom));
    checkVal("cf_level", 32'(oLevel), 32'd0);
    checkVal("cf_flags", 32'({oUnderflow, oOverflow}), 32'd0);
    checkVal("cf_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);

    // Random mixed traffic with phases biased toward filling or draining
    for (int ph = 0; ph < 12; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 85 : 15;
      for (int c = 0; c < 250; c++) begin
        step("rand", ($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < wp),
             ($urandom_range(0, 99) >= wp), 30'($urandom));
      end
    end

    // Asynchronous reset mid-stream, observed before the next edge
    for (int i = 0; i < 6; i++) step("ar_wr", 0, 1, (i > 2), 30'($urandom));
    #2;
    iRST_N = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    #3;
    iRST_N = 1'b1;
    step("ar_after", 0, 0, 1, '0);
    checkVal("ar_uf", 32'(oUnderflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
